// File: rtl/graytobinary_tracker.sv
// rtl/graytobinary_tracker.sv - synchronised Gray-to-binary decoder with up/down/illegal step classification
module graytobinary_tracker #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] g_in,
    input  logic             en,
    output logic [WIDTH-1:0] b_out,
    output logic             out_valid,
    output logic             step_up,
    output logic             step_dn,
    output logic             err,
    output logic [7:0]       err_count
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] b_out_q, b_out_d;
    logic [WIDTH-1:0] b_prev_q, b_prev_d;
    logic             primed_q, primed_d;
    logic             cmp_pend_q, cmp_pend_d;
    logic             step_up_q, step_up_d;
    logic             step_dn_q, step_dn_d;
    logic             err_q, err_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [WIDTH-1:0] gs_bin;
    logic [WIDTH-1:0] delta;

    always_comb begin
        sync_d[0] = g_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        gs_bin[WIDTH-1] = sync_q[SYNC_STAGES-1][WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            gs_bin[i] = gs_bin[i+1] ^ sync_q[SYNC_STAGES-1][i];
        end
    end

    assign delta = b_out_q - b_prev_q;

    always_comb begin
        b_out_d     = b_out_q;
        b_prev_d    = b_prev_q;
        primed_d    = 1'b0;
        cmp_pend_d  = 1'b0;
        step_up_d   = 1'b0;
        step_dn_d   = 1'b0;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        if (en) begin
            b_prev_d   = b_out_q;
            b_out_d    = gs_bin;
            primed_d   = 1'b1;
            // only a decode that follows an earlier primed decode is compared
            cmp_pend_d = primed_q;
            if (cmp_pend_q) begin
                if (delta == WIDTH'(1)) begin
                    step_up_d = 1'b1;
                end else if (delta == {WIDTH{1'b1}}) begin
                    step_dn_d = 1'b1;
                end else if (delta != '0) begin
                    err_d = 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            b_out_q     <= '0;
            b_prev_q    <= '0;
            primed_q    <= 1'b0;
            cmp_pend_q  <= 1'b0;
            step_up_q   <= 1'b0;
            step_dn_q   <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            b_out_q     <= b_out_d;
            b_prev_q    <= b_prev_d;
            primed_q    <= primed_d;
            cmp_pend_q  <= cmp_pend_d;
            step_up_q   <= step_up_d;
            step_dn_q   <= step_dn_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign b_out     = b_out_q;
    assign out_valid = primed_q;
    assign step_up   = step_up_q;
    assign step_dn   = step_dn_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_graytobinary_tracker.sv
// tb/tb_graytobinary_tracker.sv - self-checking bench for graytobinary_tracker
module tb_graytobinary_tracker;

    localparam int W = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] g_in = '0;
    logic         en = 1'b0;
    logic [W-1:0] b_out;
    logic         out_valid, step_up, step_dn, err;
    logic [7:0]   err_count;

    int n_pass = 0;
    int n_total = 0;

    // reference model state
    logic [W-1:0] pipe[$];
    logic [W-1:0] m_b, m_prev;
    bit           m_primed, m_pend, m_up, m_dn, m_err;
    int           m_cnt;

    graytobinary_tracker #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .g_in(g_in), .en(en),
        .b_out(b_out), .out_valid(out_valid), .step_up(step_up),
        .step_dn(step_dn), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [W-1:0] b2g(input int v);
        logic [W-1:0] b;
        b = W'(v);
        return b ^ (b >> 1);
    endfunction

    // one clock edge: advance the model with the inputs the DUT sees, then settle
    task automatic tick();
        logic [W-1:0] d, gs;
        bit pend_n;
        @(posedge clk);
        m_up = 0; m_dn = 0; m_err = 0;
        if (rst) begin
            pipe.delete();
            for (int i = 0; i < S; i++) pipe.push_back('0);
            m_b = '0; m_prev = '0; m_primed = 0; m_pend = 0; m_cnt = 0;
        end else begin
            gs = pipe.pop_front();
            pipe.push_back(g_in);
            if (en && m_pend) begin
                d = m_b - m_prev;
                if (d == 1) m_up = 1;
                else if (d == {W{1'b1}}) m_dn = 1;
                else if (d != 0) begin
                    m_err = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            pend_n = en && m_primed;
            if (en) begin
                m_prev = m_b; m_b = g2b(gs); m_primed = 1;
            end else begin
                m_primed = 0;
            end
            m_pend = pend_n;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; g_in = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if ({b_out, out_valid, step_up, step_dn, err, err_count} !== '0)
                $display("FAIL reset_outputs cycle %0d got b=%0d v=%0b u=%0b d=%0b e=%0b c=%0d want all 0",
                         i, b_out, out_valid, step_up, step_dn, err, err_count);
            else n_pass++;
        end
        rst = 0; g_in = '0;
        tick();
        n_total++;
        if ({step_up, step_dn, err} !== 3'b000)
            $display("FAIL reset_release_pulse got %b want 000", {step_up, step_dn, err});
        else n_pass++;
    endtask

    task automatic test_up_count();
        int ups = 0, errs = 0;
        for (int i = 0; i < 16; i++) begin
            g_in = b2g(i);
            tick();
            ups += step_up; errs += err;
            if (i >= 2) begin
                n_total++;
                if (b_out !== W'(i - 2))
                    $display("FAIL up_latency i=%0d got %0d want %0d", i, b_out, i - 2);
                else n_pass++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            ups += step_up; errs += err;
        end
        n_total++;
        if (ups != 15) $display("FAIL up_count_pulses got %0d want 15", ups); else n_pass++;
        n_total++;
        if (errs != 0 || err_count !== 8'd0)
            $display("FAIL up_count_err got pulses=%0d count=%0d want 0/0", errs, err_count);
        else n_pass++;
        n_total++;
        if (b_out !== 4'd15 || out_valid !== 1'b1)
            $display("FAIL up_count_final got b=%0d v=%0b want 15/1", b_out, out_valid);
        else n_pass++;
    endtask

    task automatic test_wrap_down();
        int ups = 0, dns = 0, errs = 0;
        g_in = 4'b0000;
        for (int i = 0; i < 4; i++) begin tick(); ups += step_up; dns += step_dn; errs += err; end
        n_total++;
        if (ups != 1 || dns != 0 || b_out !== 4'd0)
            $display("FAIL wrap_up got ups=%0d dns=%0d b=%0d want 1/0/0", ups, dns, b_out);
        else n_pass++;
        ups = 0; dns = 0;
        g_in = 4'b1000;
        for (int i = 0; i < 4; i++) begin tick(); ups += step_up; dns += step_dn; errs += err; end
        n_total++;
        if (ups != 0 || dns != 1 || b_out !== 4'd15 || errs != 0)
            $display("FAIL wrap_down got ups=%0d dns=%0d b=%0d errs=%0d want 0/1/15/0", ups, dns, b_out, errs);
        else n_pass++;
    endtask

    task automatic test_illegal_jump();
        int errs = 0;
        g_in = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        g_in = 4'b0011;
        for (int i = 0; i < 4; i++) begin tick(); errs += err; end
        n_total++;
        if (errs != 1 || err_count !== 8'd1 || b_out !== 4'd2)
            $display("FAIL illegal_first got errs=%0d count=%0d b=%0d want 1/1/2", errs, err_count, b_out);
        else n_pass++;
        errs = 0;
        g_in = 4'b0111;
        for (int i = 0; i < 4; i++) begin tick(); errs += err; end
        n_total++;
        if (errs != 1 || err_count !== 8'd2 || b_out !== 4'd5)
            $display("FAIL illegal_second got errs=%0d count=%0d b=%0d want 1/2/5", errs, err_count, b_out);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int errs = 0, m_errs = 0;
        for (int i = 0; i < 300; i++) begin
            g_in = (i % 2 == 0) ? 4'b0000 : 4'b0110;
            tick();
            errs += err; m_errs += m_err;
        end
        n_total++;
        if (err_count !== 8'd255)
            $display("FAIL sat_count got %0d want 255", err_count);
        else n_pass++;
        n_total++;
        if (errs != m_errs || errs < 290)
            $display("FAIL sat_err_pulses got %0d want %0d", errs, m_errs);
        else n_pass++;
        g_in = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        n_total++;
        if (err_count !== 8'd255) $display("FAIL sat_hold got %0d want 255", err_count); else n_pass++;
    endtask

    task automatic test_enable_gap();
        int errs = 0, ups = 0;
        en = 1; g_in = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        en = 0; g_in = 4'b0110;
        for (int i = 0; i < 4; i++) begin tick(); errs += err; end
        n_total++;
        if (out_valid !== 1'b0 || b_out !== 4'd0 || err_count !== 8'd255)
            $display("FAIL gap_hold got v=%0b b=%0d c=%0d want 0/0/255", out_valid, b_out, err_count);
        else n_pass++;
        en = 1;
        for (int i = 0; i < 3; i++) begin tick(); errs += err; ups += step_up; end
        n_total++;
        if (b_out !== 4'd4 || out_valid !== 1'b1 || errs != 0 || ups != 0)
            $display("FAIL gap_reprime got b=%0d v=%0b errs=%0d ups=%0d want 4/1/0/0", b_out, out_valid, errs, ups);
        else n_pass++;
        g_in = 4'b0111;
        for (int i = 0; i < 4; i++) begin tick(); errs += err; ups += step_up; end
        n_total++;
        if (ups != 1 || errs != 0 || b_out !== 4'd5)
            $display("FAIL gap_step got ups=%0d errs=%0d b=%0d want 1/0/5", ups, errs, b_out);
        else n_pass++;
    endtask

    task automatic test_random();
        int cur = 5;
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 5))
                0, 1: cur = (cur + 1) % 16;
                2:    cur = (cur + 15) % 16;
                3:    cur = $urandom_range(0, 15);
                default: ;
            endcase
            g_in = b2g(cur);
            tick();
            n_total++;
            if (b_out !== m_b || out_valid !== m_primed || step_up !== m_up ||
                step_dn !== m_dn || err !== m_err || err_count !== 8'(m_cnt)) begin
                bad++;
                if (bad <= 10)
                    $display("FAIL random cycle %0d got b=%0d v=%0b u=%0b d=%0b e=%0b c=%0d want b=%0d v=%0b u=%0b d=%0b e=%0b c=%0d",
                             i, b_out, out_valid, step_up, step_dn, err, err_count,
                             m_b, m_primed, m_up, m_dn, m_err, m_cnt);
            end else n_pass++;
        end
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < S; i++) pipe.push_back('0);
        m_b = '0; m_prev = '0; m_primed = 0; m_pend = 0; m_cnt = 0;
        test_reset();
        test_up_count();
        test_wrap_down();
        test_illegal_jump();
        test_saturation();
        test_enable_gap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/graytobinary_tracker.md
# graytobinary_tracker

Registered Gray-to-binary decoder with transition checking: the receive-side counterpart of the binarytogray encoder. It synchronises a Gray-coded input bus into the clock domain, converts it to binary, and classifies each sample-to-sample change as an up step, a down step or an illegal multi-bit jump. It sits at the consumer end of Gray-coded sources such as encoder position buses and cross-domain counter pointers.

## Interface
- WIDTH, 4, Gray/binary bus width (≥2)
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser (≥2)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- g_in  input  WIDTH  Gray-coded input, may be asynchronous to clk; g_in[WIDTH-1] is the MSB
- en  input  1  enables the decode and compare stages
- b_out  output  WIDTH  registered binary value of the synchronised Gray input
- out_valid  output  1  b_out holds a decoded sample taken while en=1
- step_up  output  1  one-cycle pulse: the new value is the previous value +1 mod 2^WIDTH
- step_dn  output  1  one-cycle pulse: the new value is the previous value −1 mod 2^WIDTH
- err  output  1  one-cycle pulse: the value jumped by anything other than 0 or ±1
- err_count  output  8  saturating count of err pulses

## Operation
- Synchroniser: a chain sync[0..SYNC_STAGES-1] shifts g_in in every cycle, independent of en. gs is the last stage.
- Decode stage, when en=1: b_out <= gray2bin(gs), where b[WIDTH-1]=g[WIDTH-1] and b[i]=b[i+1]^g[i]. The previous b_out is copied into b_prev.
- Priming: the internal flag primed is set on the first enabled decode. out_valid follows primed.
- Compare stage: runs on the cycle after each enabled decode, and only if primed was already set before that decode. It computes delta = (b_out − b_prev) mod 2^WIDTH:
  - delta=0 → no pulse.
  - delta=1 → step_up=1.
  - delta=2^WIDTH−1 → step_dn=1.
  - Any other delta → err=1, and err_count increments unless it is already 255.
- step_up, step_dn and err are mutually exclusive and each lasts exactly one cycle.
- Wrap-around counts as a legal step: 2^WIDTH−1 → 0 is step_up, and 0 → 2^WIDTH−1 is step_dn.
- en=0:
  - b_out and err_count hold.
  - step_up, step_dn and err are 0.
  - primed and out_valid clear.
  - The first sample after en rises only re-primes; it never produces a step or err.
- Reset (rst=1 at an edge):
  - Clears all sync stages, b_out, b_prev, primed, out_valid, step_up, step_dn, err and err_count.
  - Reset mid-operation discards any in-flight samples and pending pulses.
  - After rst falls, the first enabled decode only primes.

## Timing
- Reset values: b_out=0, out_valid=0, step_up=0, step_dn=0, err=0, err_count=0.
- Let g_in be captured into sync[0] at edge k, with en=1 throughout.
  - gs holds that value after edge k+SYNC_STAGES−1.
  - b_out holds it after edge k+SYNC_STAGES.
  - The resulting step_up/step_dn/err pulse is valid after edge k+SYNC_STAGES+1.
- With the default SYNC_STAGES=2, latency from capture edge to b_out is 2 edges, and to the classification pulse is 3 edges.
- A new sample can arrive every cycle, so the block has full throughput. Back-to-back steps produce back-to-back pulses.
- err_count updates on the same edge that asserts err.
- When en falls, any pulse already scheduled from the last enabled decode is suppressed.

## Test plan
- Reset: hold rst=1 for 3 cycles with g_in=4'b1010 → every output is 0; on the release cycle no pulse fires.
- Up count: en=1, drive the Gray sequence of 0..15 (0000, 0001, 0011, 0010, …, 1000), one value per cycle → b_out tracks 0..15 with latency 2. step_up pulses 15 times (none for the priming sample); err_count stays 0.
- Wrap and down: from steady Gray 1000 (b_out=15), drive 0000 → one step_up. Then drive 1000 → one step_dn, and b_out returns to 15.
- Illegal jump: steady 0000, then 0011 (binary 2) → err pulses once, err_count=1, b_out=2. Next, 0111 (binary 5) → err again, err_count=2.
- Saturation: force 300 alternating 0000/0110 jumps → err_count reaches 255 and holds there, while err keeps pulsing.
- Enable gap: en=0 while g_in moves 0000 → 0110, then en=1 → b_out updates to 4 and out_valid rises. No err fires. The next legal step (0111 = binary 5) gives step_up.
